// File: rtl/recon_dma_ctrl.sv
// recon_dma_ctrl
// Parses a recon header from the first beat of an ingress AXI-Stream frame and
// issues either a DMA write or a DMA read descriptor. For writes, the payload
// following the header is realigned to byte 0 and forwarded on m_axis. The
// payload is clipped to the header length. Any length disagreement is reported
// on stat_frame_err.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_axis_*                 ingress frames (header in beat 0 at HDR_OFFSET)
//   m_axis_write_desc_*      DMA write descriptor (addr/len/tag, valid/ready)
//   m_axis_read_desc_*       DMA read descriptor (addr/len/tag, valid/ready)
//   m_axis_t*                realigned write payload, registered output
//   stat_frame_ok/_err       one-cycle pulses per completed / failed frame
module recon_dma_ctrl #(
    parameter int          DATA_WIDTH = 512,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int          ADDR_WIDTH = 34,
    parameter int          LEN_WIDTH  = 20,
    parameter int          TAG_WIDTH  = 8,
    parameter int          HDR_OFFSET = 46,
    parameter logic [15:0] MAGIC      = 16'hF0E1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,

    output logic [ADDR_WIDTH-1:0] m_axis_write_desc_addr,
    output logic [LEN_WIDTH-1:0]  m_axis_write_desc_len,
    output logic [TAG_WIDTH-1:0]  m_axis_write_desc_tag,
    output logic                  m_axis_write_desc_valid,
    input  logic                  m_axis_write_desc_ready,

    output logic [ADDR_WIDTH-1:0] m_axis_read_desc_addr,
    output logic [LEN_WIDTH-1:0]  m_axis_read_desc_len,
    output logic [TAG_WIDTH-1:0]  m_axis_read_desc_tag,
    output logic                  m_axis_read_desc_valid,
    input  logic                  m_axis_read_desc_ready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic                  stat_frame_ok,
    output logic                  stat_frame_err
);

    // First payload byte in beat 0, and how many payload bytes beat 0 carries.
    localparam int S_BYTES   = HDR_OFFSET + 16;
    localparam int RES_BYTES = KEEP_WIDTH - S_BYTES;
    localparam int CNT_W     = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, DESC, DATA, FLUSH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  is_read_q, is_read_d;
    logic                  first_last_q, first_last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [KEEP_WIDTH-1:0] res_keep_q, res_keep_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  stat_ok_q, stat_ok_d;
    logic                  stat_err_q, stat_err_d;
    logic                  s_ready_c;

    function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + CNT_W'(k[i]);
        return c;
    endfunction

    // tkeep covering exactly the lowest n bytes of a beat.
    function automatic logic [KEEP_WIDTH-1:0] low_mask(input logic [LEN_WIDTH-1:0] n);
        logic [KEEP_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (64'(i) < 64'(n));
        return m;
    endfunction

    // Header fields as seen on the current input beat.
    logic [15:0]           hdr_magic;
    logic [1:0]            hdr_func;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [ADDR_WIDTH-1:0] hdr_addr;

    assign hdr_magic = s_axis_tdata[HDR_OFFSET*8 +: 16];
    assign hdr_func  = s_axis_tdata[(HDR_OFFSET+2)*8 +: 2];
    assign hdr_len   = s_axis_tdata[(HDR_OFFSET+4)*8 +: LEN_WIDTH];
    assign hdr_addr  = s_axis_tdata[(HDR_OFFSET+8)*8 +: ADDR_WIDTH];

    // Realignment: residual bytes sit low, the low S bytes of the incoming
    // beat fill the rest; the bytes from S upward become the next residual.
    logic [DATA_WIDTH-1:0] raw_data, nres_data;
    logic [KEEP_WIDTH-1:0] raw_keep, nres_keep, rem_mask;
    logic [CNT_W-1:0]      raw_cnt, nres_cnt, res_cnt;
    logic                  out_slot;

    assign raw_data  = res_data_q | (s_axis_tdata << (RES_BYTES * 8));
    assign raw_keep  = res_keep_q | (s_axis_tkeep << RES_BYTES);
    assign nres_data = s_axis_tdata >> (S_BYTES * 8);
    assign nres_keep = s_axis_tkeep >> S_BYTES;
    assign raw_cnt   = popcount(raw_keep);
    assign nres_cnt  = popcount(nres_keep);
    assign res_cnt   = popcount(res_keep_q);
    assign rem_mask  = low_mask(rem_q);
    assign out_slot  = !out_valid_q || m_axis_tready;

    // State and datapath registers; everything returns to idle/zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_read_q    <= 1'b0;
            first_last_q <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            tag_q        <= '0;
            wr_valid_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            res_data_q   <= '0;
            res_keep_q   <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            stat_ok_q    <= 1'b0;
            stat_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_read_q    <= is_read_d;
            first_last_q <= first_last_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            tag_q        <= tag_d;
            wr_valid_q   <= wr_valid_d;
            rd_valid_q   <= rd_valid_d;
            res_data_q   <= res_data_d;
            res_keep_q   <= res_keep_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            stat_ok_q    <= stat_ok_d;
            stat_err_q   <= stat_err_d;
        end
    end

    // Next-state, descriptor handshake, realignment and status decisions.
    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        first_last_d = first_last_q;
        addr_d       = addr_q;
        len_d        = len_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        wr_valid_d   = wr_valid_q;
        rd_valid_d   = rd_valid_q;
        res_data_d   = res_data_q;
        res_keep_d   = res_keep_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        stat_ok_d    = 1'b0;
        stat_err_d   = 1'b0;
        s_ready_c    = 1'b0;

        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                s_ready_c = 1'b1;
                if (s_axis_tvalid) begin
                    if (hdr_magic != MAGIC) begin
                        // Foreign frame: skip silently. A single-beat frame is
                        // already complete, so only multi-beat frames drain.
                        if (!s_axis_tlast) state_d = DRAIN;
                    end else if (hdr_len == '0 || hdr_func[1]) begin
                        stat_err_d = 1'b1;
                        if (!s_axis_tlast) state_d = DRAIN;
                    end else begin
                        is_read_d    = hdr_func[0];
                        addr_d       = hdr_addr;
                        len_d        = hdr_len;
                        rem_d        = hdr_len;
                        first_last_d = s_axis_tlast;
                        res_data_d   = nres_data;
                        res_keep_d   = nres_keep;
                        wr_valid_d   = !hdr_func[0];
                        rd_valid_d   = hdr_func[0];
                        state_d      = DESC;
                    end
                end
            end

            DESC: begin
                if ((wr_valid_q && m_axis_write_desc_ready) ||
                    (rd_valid_q && m_axis_read_desc_ready)) begin
                    wr_valid_d = 1'b0;
                    rd_valid_d = 1'b0;
                    tag_d      = tag_q + TAG_WIDTH'(1);
                    if (is_read_q) begin
                        if (first_last_q) begin
                            stat_ok_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            stat_err_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end else begin
                        // A write whose header beat was also the last beat
                        // has only the residual left to send.
                        state_d = first_last_q ? FLUSH : DATA;
                    end
                end
            end

            DATA: begin
                s_ready_c = out_slot;
                if (s_axis_tvalid && out_slot) begin
                    out_valid_d = 1'b1;
                    out_data_d  = raw_data;
                    res_data_d  = nres_data;
                    res_keep_d  = nres_keep;
                    if (64'(raw_cnt) >= 64'(rem_q)) begin
                        out_keep_d = rem_mask;
                        out_last_d = 1'b1;
                        rem_d      = '0;
                        if (!s_axis_tlast) begin
                            stat_err_d = 1'b1;
                            state_d    = DRAIN;
                        end else begin
                            // Ending together is only a match when no payload
                            // byte was clipped off, here or in the residual.
                            if (64'(raw_cnt) == 64'(rem_q) && nres_cnt == '0) begin
                                stat_ok_d = 1'b1;
                            end else begin
                                stat_err_d = 1'b1;
                            end
                            state_d = IDLE;
                        end
                    end else begin
                        out_keep_d = raw_keep;
                        out_last_d = 1'b0;
                        rem_d      = rem_q - LEN_WIDTH'(raw_cnt);
                        if (s_axis_tlast) begin
                            if (nres_cnt != '0) begin
                                state_d = FLUSH;
                            end else begin
                                out_last_d = 1'b1;
                                stat_err_d = 1'b1;
                                state_d    = IDLE;
                            end
                        end
                    end
                end
            end

            FLUSH: begin
                // Input is held off here so the next frame's header beat is
                // not taken before this frame's last beat is out.
                if (out_slot) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_data_q;
                    out_last_d  = 1'b1;
                    out_keep_d  = (64'(res_cnt) >= 64'(rem_q)) ? rem_mask : res_keep_q;
                    if (64'(res_cnt) == 64'(rem_q)) begin
                        stat_ok_d = 1'b1;
                    end else begin
                        stat_err_d = 1'b1;
                    end
                    rem_d      = '0;
                    res_data_d = '0;
                    res_keep_d = '0;
                    state_d    = IDLE;
                end
            end

            DRAIN: begin
                s_ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign s_axis_tready           = s_ready_c & ~rst;

    assign m_axis_write_desc_addr  = addr_q;
    assign m_axis_write_desc_len   = len_q;
    assign m_axis_write_desc_tag   = tag_q;
    assign m_axis_write_desc_valid = wr_valid_q;

    assign m_axis_read_desc_addr   = addr_q;
    assign m_axis_read_desc_len    = len_q;
    assign m_axis_read_desc_tag    = tag_q;
    assign m_axis_read_desc_valid  = rd_valid_q;

    assign m_axis_tdata            = out_data_q;
    assign m_axis_tkeep            = out_keep_q;
    assign m_axis_tvalid           = out_valid_q;
    assign m_axis_tlast            = out_last_q;

    assign stat_frame_ok           = stat_ok_q;
    assign stat_frame_err          = stat_err_q;

endmodule

// File: tb/tb_recon_dma_ctrl.sv
// Testbench for recon_dma_ctrl. Frames are generated with random payload,
// a reference model derives the expected descriptors, output beats and status
// pulses from the header and frame length, and a monitor compares everything
// the DUT presents against those scoreboard queues.
module tb_recon_dma_ctrl;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int AW = 34;
   localparam int LW = 20;
   localparam int TW = 8;
   localparam int HO = 46;
   localparam int SB = HO + 16;
   localparam logic [15:0] MAGIC = 16'hF0E1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [AW-1:0] wd_addr, rd_addr;
   logic [LW-1:0] wd_len, rd_len;
   logic [TW-1:0] wd_tag, rd_tag;
   logic          wd_valid, rd_valid;
   logic          wd_ready = 1'b0;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid, m_tlast;
   logic          m_tready = 1'b0;
   logic          stat_ok, stat_err;

   recon_dma_ctrl dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_write_desc_addr(wd_addr), .m_axis_write_desc_len(wd_len),
      .m_axis_write_desc_tag(wd_tag), .m_axis_write_desc_valid(wd_valid),
      .m_axis_write_desc_ready(wd_ready),
      .m_axis_read_desc_addr(rd_addr), .m_axis_read_desc_len(rd_len),
      .m_axis_read_desc_tag(rd_tag), .m_axis_read_desc_valid(rd_valid),
      .m_axis_read_desc_ready(rd_ready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .stat_frame_ok(stat_ok), .stat_frame_err(stat_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [TW-1:0] tag;
   } desc_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   desc_t exp_wr[$];
   desc_t exp_rd[$];
   beat_t exp_out[$];
   bit    exp_stat[$];
   int    model_tag = 0;

   // ready modes: 0 always high, 1 random, 2 low for five valid cycles, 3 never
   int out_mode = 0;
   int wr_mode = 0;
   int rd_mode = 0;
   int rd_low_cnt = 0;
   int rd_valid_cnt = 0;
   int last_rd_valid_cycles = 0;

   logic [DW-1:0] fr_data[$];
   logic [KW-1:0] fr_keep[$];

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reportUnexpected(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got valid=1, expected nothing pending", name);
   endtask

   function automatic logic [DW-1:0] maskData(input logic [DW-1:0] d, input logic [KW-1:0] k);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < KW; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // Ready drivers change just after the rising edge.
   always @(posedge clk) begin
      #1;
      case (out_mode)
         0: m_tready = 1'b1;
         1: m_tready = 1'($urandom_range(0, 1));
         default: m_tready = 1'b0;
      endcase
      case (wr_mode)
         0: wd_ready = 1'b1;
         1: wd_ready = 1'($urandom_range(0, 1));
         default: wd_ready = 1'b0;
      endcase
      case (rd_mode)
         0: rd_ready = 1'b1;
         1: rd_ready = 1'($urandom_range(0, 1));
         2: rd_ready = (rd_low_cnt >= 5);
         default: rd_ready = 1'b0;
      endcase
   end

   // Monitor: every presented descriptor/beat/pulse is compared to the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (wd_valid) begin
            if (exp_wr.size() == 0) reportUnexpected("wr_desc_unexpected");
            else begin
               checkOutput("wr_desc_addr", DW'(wd_addr), DW'(exp_wr[0].addr));
               checkOutput("wr_desc_len", DW'(wd_len), DW'(exp_wr[0].len));
               checkOutput("wr_desc_tag", DW'(wd_tag), DW'(exp_wr[0].tag));
               if (wd_ready) void'(exp_wr.pop_front());
            end
         end
         if (rd_valid) begin
            rd_valid_cnt++;
            if (!rd_ready) rd_low_cnt++;
            if (exp_rd.size() == 0) reportUnexpected("rd_desc_unexpected");
            else begin
               checkOutput("rd_desc_addr", DW'(rd_addr), DW'(exp_rd[0].addr));
               checkOutput("rd_desc_len", DW'(rd_len), DW'(exp_rd[0].len));
               checkOutput("rd_desc_tag", DW'(rd_tag), DW'(exp_rd[0].tag));
               if (rd_ready) void'(exp_rd.pop_front());
            end
            if (rd_ready) begin
               last_rd_valid_cycles = rd_valid_cnt;
               rd_valid_cnt = 0;
               rd_low_cnt = 0;
            end
         end
         if (m_tvalid) begin
            if (exp_out.size() == 0) reportUnexpected("out_beat_unexpected");
            else begin
               checkOutput("out_keep", DW'(m_tkeep), DW'(exp_out[0].keep));
               checkOutput("out_last", DW'(m_tlast), DW'(exp_out[0].last));
               checkOutput("out_data", maskData(m_tdata, exp_out[0].keep), exp_out[0].data);
               if (m_tready) void'(exp_out.pop_front());
            end
         end
         if (stat_ok || stat_err) begin
            if (exp_stat.size() == 0) reportUnexpected("stat_unexpected");
            else begin
               checkOutput("stat_ok_err", DW'({stat_ok, stat_err}),
                           DW'({exp_stat[0], !exp_stat[0]}));
               void'(exp_stat.pop_front());
            end
         end
      end
   end

   task automatic driveBeat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      bit acc;
      int budget;
      s_tdata = d;
      s_tkeep = k;
      s_tlast = l;
      s_tvalid = 1'b1;
      acc = 0;
      budget = 0;
      while (!acc && budget < 2000) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         budget++;
      end
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("[TB] FAIL beat_accept_timeout: got tready never high, expected beat taken");
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   // Builds a frame, predicts the DUT response from the header rules and the
   // payload byte count, then drives the first ndrive beats.
   task automatic applyStimulus(input logic [15:0] magic, input logic [1:0] func,
                                input logic [31:0] len, input logic [63:0] addr,
                                input int nbeats, input int last_bytes, input int ndrive);
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      byte unsigned  pay[$];
      int            m;
      int            elen;
      beat_t         b;
      desc_t         ds;
      fr_data.delete();
      fr_keep.delete();
      for (int i = 0; i < nbeats; i++) begin
         for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
         k = '1;
         if (i != 0 && i == nbeats - 1)
            for (int j = 0; j < KW; j++) k[j] = (j < last_bytes);
         if (i == 0) begin
            d[HO*8 +: 16] = magic;
            d[(HO+2)*8 +: 2] = func;
            d[(HO+4)*8 +: 32] = len;
            d[(HO+8)*8 +: 64] = addr;
         end
         fr_data.push_back(d);
         fr_keep.push_back(k);
      end

      elen = int'(len[LW-1:0]);
      if (magic == MAGIC) begin
         if (elen == 0 || func >= 2'd2) exp_stat.push_back(1'b0);
         else begin
            ds.addr = addr[AW-1:0];
            ds.len = len[LW-1:0];
            ds.tag = TW'(model_tag);
            model_tag = (model_tag + 1) % (1 << TW);
            if (func == 2'd1) begin
               exp_rd.push_back(ds);
               exp_stat.push_back(nbeats == 1);
            end else begin
               exp_wr.push_back(ds);
               for (int j = SB; j < KW; j++) pay.push_back(fr_data[0][j*8 +: 8]);
               for (int i = 1; i < nbeats; i++)
                  for (int j = 0; j < KW; j++)
                     if (fr_keep[i][j]) pay.push_back(fr_data[i][j*8 +: 8]);
               m = (pay.size() < elen) ? pay.size() : elen;
               for (int off = 0; off < m; off += KW) begin
                  b.data = '0;
                  b.keep = '0;
                  for (int j = 0; j < KW && off + j < m; j++) begin
                     b.data[j*8 +: 8] = pay[off + j];
                     b.keep[j] = 1'b1;
                  end
                  b.last = (off + KW >= m);
                  exp_out.push_back(b);
               end
               exp_stat.push_back(pay.size() == elen);
            end
         end
      end

      for (int i = 0; i < ndrive; i++) driveBeat(fr_data[i], fr_keep[i], i == nbeats - 1);
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while ((exp_wr.size() + exp_rd.size() + exp_out.size() + exp_stat.size()) != 0 && budget < 3000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tagname);
      checkOutput({tagname, "_s_tready"}, DW'(s_tready), '0);
      checkOutput({tagname, "_wr_valid"}, DW'(wd_valid), '0);
      checkOutput({tagname, "_rd_valid"}, DW'(rd_valid), '0);
      checkOutput({tagname, "_m_tvalid"}, DW'(m_tvalid), '0);
      checkOutput({tagname, "_m_tlast"}, DW'(m_tlast), '0);
      checkOutput({tagname, "_stat"}, DW'({stat_ok, stat_err}), '0);
   endtask

   initial begin
      int nb, lb, pl, fsel;
      logic [1:0] fn;
      logic [15:0] mg;
      logic [31:0] ln;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkIdleOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] read with held-off descriptor ready");
      rd_mode = 2;
      applyStimulus(MAGIC, 2'd1, 32'd4096, 64'h1_0000_0000, 1, 64, 1);
      waitDrain();
      checkOutput("rd_valid_cycles", DW'(last_rd_valid_cycles), DW'(6));
      rd_mode = 0;
      applyStimulus(MAGIC, 2'd1, 32'd64, 64'h0_0000_1000, 1, 64, 1);

      $display("[TB] foreign magic frame");
      applyStimulus(16'h1234, 2'd0, 32'd100, 64'h40, 4, 64, 4);

      $display("[TB] short and long write frames");
      applyStimulus(MAGIC, 2'd0, 32'd200, 64'h2000, 2, 64, 2);
      applyStimulus(MAGIC, 2'd0, 32'd10, 64'h3000, 3, 64, 3);

      $display("[TB] len 1000 under random output backpressure");
      out_mode = 1;
      applyStimulus(MAGIC, 2'd0, 32'd1000, 64'h4000, 17, 38, 17);
      waitDrain();

      $display("[TB] randomized frames");
      for (int f = 0; f < 24; f++) begin
         out_mode = $urandom_range(0, 1);
         wr_mode = $urandom_range(0, 1);
         rd_mode = $urandom_range(0, 1);
         nb = $urandom_range(1, 6);
         lb = $urandom_range(1, 64);
         pl = (nb == 1) ? (KW - SB) : (KW - SB) + KW * (nb - 2) + lb;
         ln = 32'(pl + $urandom_range(0, 4) - 2);
         if ($urandom_range(0, 15) == 0) ln = 32'd0;
         fsel = $urandom_range(0, 9);
         fn = (fsel < 6) ? 2'd0 : (fsel < 9) ? 2'd1 : 2'($urandom_range(2, 3));
         mg = ($urandom_range(0, 9) == 0) ? 16'h5A5A : MAGIC;
         applyStimulus(mg, fn, ln, {$urandom, $urandom}, nb, lb, nb);
      end
      waitDrain();
      out_mode = 0;
      wr_mode = 0;
      rd_mode = 0;

      $display("[TB] reset in the middle of a write payload");
      out_mode = 3;
      applyStimulus(MAGIC, 2'd0, 32'd300, 64'h5000, 6, 64, 2);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkIdleOutputs("midreset");
      exp_out.delete();
      exp_stat.delete();
      exp_wr.delete();
      exp_rd.delete();
      model_tag = 0;
      out_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(MAGIC, 2'd0, 32'd130, 64'h6000, 3, 64, 3);
      waitDrain();

      checkOutput("left_wr_desc", DW'(exp_wr.size()), '0);
      checkOutput("left_rd_desc", DW'(exp_rd.size()), '0);
      checkOutput("left_out_beats", DW'(exp_out.size()), '0);
      checkOutput("left_stat", DW'(exp_stat.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
